mem_bank_arbiter: RTL

MEM_BANK_ARBITER -- requirements
Module: mem_bank_arbiter

---
 rtl/mem_bank_arbiter_if.sv | 38 +++
 rtl/mem_bank_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mem_bank_arbiter_if.sv
// rtl/mem_bank_arbiter_if.sv - requester and memory-bank signal bundle for mem_bank_arbiter
interface mem_bank_arbiter_if;
    logic       req0;
    logic       req1;
    logic       we0;
    logic       we1;
    logic [2:0] addr0;
    logic [2:0] addr1;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic       gnt0;
    logic       gnt1;
    logic       rvalid0;
    logic       rvalid1;
    logic [7:0] rdata0;
    logic [7:0] rdata1;
    logic       mem_wr;
    logic       mem_rd;
    logic [2:0] mem_addr;
    logic [7:0] mem_din;
    logic       mem_resetn;
    logic [7:0] mem_dout;
    logic       mem_error;
    logic       busy;
    logic       err;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout, mem_error,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_wr, mem_rd, mem_addr, mem_din, mem_resetn, busy, err
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout, mem_error,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_wr, mem_rd, mem_addr, mem_din, mem_resetn, busy, err
    );
endinterface

// File: rtl/mem_bank_arbiter.sv
// rtl/mem_bank_arbiter.sv - two-port round-robin arbiter in front of a single memory bank
module mem_bank_arbiter (
    input  logic              clk,
    input  logic              reset,
    mem_bank_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0] r_state;
    logic       r_last;
    logic       r_win;
    logic       r_we;
    logic [1:0] r_req_q;
    logic [1:0] r_gnt_seen;
    logic [1:0] r_gnt;
    logic [1:0] r_rvalid;
    logic [7:0] r_rdata0;
    logic [7:0] r_rdata1;
    logic       r_mem_wr;
    logic       r_mem_rd;
    logic [2:0] r_mem_addr;
    logic [7:0] r_mem_din;
    logic       r_mem_resetn;
    logic       r_busy;
    logic       r_err;

    logic [1:0] w_req;
    logic       w_win;
    logic       w_we;
    logic [2:0] w_addr;
    logic [7:0] w_wdata;
    logic [1:0] w_drop;
    logic       w_err_set;

    always_comb begin
        w_req   = {bus.req1, bus.req0};
        w_win   = (w_req == 2'b11) ? ~r_last : w_req[1];
        w_we    = w_win ? bus.we1    : bus.we0;
        w_addr  = w_win ? bus.addr1  : bus.addr0;
        w_wdata = w_win ? bus.wdata1 : bus.wdata0;
        // A request that was high last edge and is gone now, without a grant shown or seen, was abandoned.
        w_drop    = r_req_q & ~w_req & ~r_gnt_seen & ~r_gnt;
        w_err_set = bus.mem_error |
                    (((r_state == IDLE) || (r_state == ISSUE)) && (w_drop != 2'b00));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last       <= 1'b1;
            r_win        <= 1'b0;
            r_we         <= 1'b0;
            r_req_q      <= 2'b00;
            r_gnt_seen   <= 2'b00;
            r_gnt        <= 2'b00;
            r_rvalid     <= 2'b00;
            r_rdata0     <= 8'h00;
            r_rdata1     <= 8'h00;
            r_mem_wr     <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_addr   <= 3'd0;
            r_mem_din    <= 8'h00;
            r_mem_resetn <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_gnt        <= 2'b00;
            r_rvalid     <= 2'b00;
            r_rdata0     <= 8'h00;
            r_rdata1     <= 8'h00;
            r_mem_wr     <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_addr   <= 3'd0;
            r_mem_din    <= 8'h00;
            r_mem_resetn <= 1'b1;
            r_req_q      <= w_req;
            r_gnt_seen   <= (r_gnt_seen | r_gnt) & w_req;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_req != 2'b00) begin
                        r_state           <= ISSUE;
                        r_busy            <= 1'b1;
                        r_win             <= w_win;
                        r_last            <= w_win;
                        r_we              <= w_we;
                        r_gnt[w_win]      <= 1'b1;
                        r_gnt_seen[w_win] <= 1'b0;
                        r_mem_wr          <= w_we;
                        r_mem_rd          <= ~w_we;
                        r_mem_addr        <= w_addr;
                        r_mem_din         <= w_wdata;
                    end
                end
                ISSUE: begin
                    r_state <= r_we ? IDLE : WAIT;
                    r_busy  <= ~r_we;
                end
                WAIT: begin
                    r_state         <= RESP;
                    r_rvalid[r_win] <= 1'b1;
                    if (r_win) begin
                        r_rdata1 <= bus.mem_dout;
                    end else begin
                        r_rdata0 <= bus.mem_dout;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt0       = r_gnt[0];
    assign bus.gnt1       = r_gnt[1];
    assign bus.rvalid0    = r_rvalid[0];
    assign bus.rvalid1    = r_rvalid[1];
    assign bus.rdata0     = r_rdata0;
    assign bus.rdata1     = r_rdata1;
    assign bus.mem_wr     = r_mem_wr;
    assign bus.mem_rd     = r_mem_rd;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_din    = r_mem_din;
    assign bus.mem_resetn = r_mem_resetn;
    assign bus.busy       = r_busy;
    assign bus.err        = r_err;
endmodule
